// File: rtl/rvfpm_result_queue_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : pa_rvfpm (package)
// Brief   : Shared types and helpers for the rvfpm result queue.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package pa_rvfpm;

  localparam int RESQ_DEPTH_DEFAULT = 4;
  localparam int RESQ_PTR_W         = $clog2(RESQ_DEPTH_DEFAULT);

  typedef enum logic [1:0] {
    RESQ_FREE   = 2'd0,
    RESQ_PEND   = 2'd1,
    RESQ_RETIRE = 2'd2,
    RESQ_DROP   = 2'd3
  } resq_state_e;

  // Control part of an entry; id and data live in separately sized arrays.
  typedef struct packed {
    resq_state_e state;
    logic [4:0]  rd;
    logic        wb;
    logic        done;
    logic        committed;
    logic        killed;
  } resq_entry_t;

  function automatic resq_state_e resq_resolve(input resq_state_e st,
                                               input logic        done,
                                               input logic        committed,
                                               input logic        killed);
    resq_state_e nxt;
    nxt = st;
    if (st == RESQ_PEND || st == RESQ_RETIRE) begin
      if (killed)
        nxt = RESQ_DROP;
      else if (st == RESQ_PEND && done && committed)
        nxt = RESQ_RETIRE;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rvfpm_result_queue_id_match.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : rvfpm_resq_id_match
// Brief   : Combinational id lookup returning a one-hot entry hit (lowest wins).
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module rvfpm_resq_id_match #(
  parameter int N   = 4,
  parameter int IDW = 4
) (
  input  logic [N-1:0]     mask,
  input  logic [N*IDW-1:0] ids,
  input  logic [IDW-1:0]   key,
  output logic [N-1:0]     hit
);

  logic w_found;

  always_comb begin
    hit     = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && mask[i] && (ids[i*IDW +: IDW] == key)) begin
        hit[i]  = 1'b1;
        w_found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rvfpm_result_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : rvfpm_result_queue
// Brief   : In-order result/commit tracking queue between the rvfpm execution
//           channels and the XIF result interface.
//           Optional fflags capture/accumulation: RVFPM_RESQ_FFLAGS_EN.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module rvfpm_result_queue
  import pa_rvfpm::*;
#(
  parameter int DEPTH      = 4,
  parameter int NUM_CH     = 2,
  parameter int X_ID_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         ck,
  input  logic                         rst,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [X_ID_WIDTH-1:0]        alloc_id,
  input  logic [4:0]                   alloc_rd,
  input  logic                         alloc_wb,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic [NUM_CH*X_ID_WIDTH-1:0] ch_id,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic                         commit_valid,
  input  logic [X_ID_WIDTH-1:0]        commit_id,
  input  logic                         commit_kill,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic [X_ID_WIDTH-1:0]        result_id,
  output logic [4:0]                   result_rd,
  output logic [DATA_WIDTH-1:0]        result_data,
  output logic                         result_we,
`ifdef RVFPM_RESQ_FFLAGS_EN
  input  logic [NUM_CH*5-1:0]          ch_fflags,
  input  logic                         fflags_clr,
  output logic [4:0]                   result_fflags,
  output logic [4:0]                   fflags_acc,
`endif
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  resq_entry_t               r_ent  [DEPTH];
  logic [X_ID_WIDTH-1:0]     r_id   [DEPTH];
  logic [DATA_WIDTH-1:0]     r_data [DEPTH];
  logic [PTR_W-1:0]          r_head;
  logic [PTR_W-1:0]          r_tail;
  logic [CNT_W-1:0]          r_count;

  resq_entry_t               w_nent  [DEPTH];
  logic [X_ID_WIDTH-1:0]     w_nid   [DEPTH];
  logic [DATA_WIDTH-1:0]     w_ndata [DEPTH];

  logic [DEPTH*X_ID_WIDTH-1:0]   w_ids_flat;
  logic [DEPTH-1:0]              w_ch_mask;
  logic [DEPTH-1:0]              w_cm_mask;
  logic [DEPTH-1:0]              w_cm_hit;
  logic [NUM_CH-1:0][DEPTH-1:0]  w_ch_hit;

  logic        w_alloc;
  logic        w_cm_new;
  logic        w_cm_old;
  logic        w_pop;
  resq_entry_t w_head;

`ifdef RVFPM_RESQ_FFLAGS_EN
  logic [4:0] r_ff  [DEPTH];
  logic [4:0] w_nff [DEPTH];
  logic [4:0] r_acc;
`endif

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
      assign w_ids_flat[i*X_ID_WIDTH +: X_ID_WIDTH] = r_id[i];
      assign w_ch_mask[i] = (r_ent[i].state == RESQ_PEND) && !r_ent[i].done;
      // Retired entries can still be killed but never re-committed.
      assign w_cm_mask[i] = ((r_ent[i].state == RESQ_PEND) && !r_ent[i].committed) ||
                            ((r_ent[i].state == RESQ_RETIRE) && commit_kill);
    end
  endgenerate

  rvfpm_resq_id_match #(.N(DEPTH), .IDW(X_ID_WIDTH)) u_cm_match (
    .mask (w_cm_mask),
    .ids  (w_ids_flat),
    .key  (commit_id),
    .hit  (w_cm_hit)
  );

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      rvfpm_resq_id_match #(.N(DEPTH), .IDW(X_ID_WIDTH)) u_ch_match (
        .mask (w_ch_mask),
        .ids  (w_ids_flat),
        .key  (ch_id[c*X_ID_WIDTH +: X_ID_WIDTH]),
        .hit  (w_ch_hit[c])
      );
    end
  endgenerate

  assign alloc_ready = (r_count < CNT_W'(DEPTH));
  assign w_alloc     = alloc_valid && alloc_ready;
  // A commit racing its own alloc belongs to the new entry.
  assign w_cm_new    = commit_valid && w_alloc && (commit_id == alloc_id);
  assign w_cm_old    = commit_valid && !w_cm_new;

  assign w_head       = r_ent[r_head];
  assign result_valid = (w_head.state == RESQ_RETIRE) && w_head.wb;
  assign w_pop        = (result_valid && result_ready) ||
                        (w_head.state == RESQ_DROP) ||
                        ((w_head.state == RESQ_RETIRE) && !w_head.wb);

  assign result_id   = result_valid ? r_id[r_head]   : '0;
  assign result_rd   = result_valid ? w_head.rd      : '0;
  assign result_data = result_valid ? r_data[r_head] : '0;
  assign result_we   = result_valid;
  assign count       = r_count;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_nent[i]  = r_ent[i];
      w_nid[i]   = r_id[i];
      w_ndata[i] = r_data[i];
`ifdef RVFPM_RESQ_FFLAGS_EN
      w_nff[i]   = r_ff[i];
`endif
      // Walk channels high to low so the lowest index has the final say.
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (ch_valid[c] && w_ch_hit[c][i]) begin
          w_nent[i].done = 1'b1;
          w_ndata[i]     = ch_data[c*DATA_WIDTH +: DATA_WIDTH];
`ifdef RVFPM_RESQ_FFLAGS_EN
          w_nff[i]       = ch_fflags[c*5 +: 5];
`endif
        end
      end
      if (w_cm_old && w_cm_hit[i]) begin
        if (commit_kill)
          w_nent[i].killed = 1'b1;
        else
          w_nent[i].committed = 1'b1;
      end
      if (w_alloc && (r_tail == PTR_W'(i))) begin
        w_nent[i].state     = RESQ_PEND;
        w_nent[i].rd        = alloc_rd;
        w_nent[i].wb        = alloc_wb;
        w_nent[i].done      = !alloc_wb;
        w_nent[i].committed = w_cm_new && !commit_kill;
        w_nent[i].killed    = w_cm_new && commit_kill;
        w_nid[i]            = alloc_id;
        w_ndata[i]          = '0;
`ifdef RVFPM_RESQ_FFLAGS_EN
        w_nff[i]            = '0;
`endif
      end
      w_nent[i].state = resq_resolve(w_nent[i].state, w_nent[i].done,
                                     w_nent[i].committed, w_nent[i].killed);
      if (w_pop && (r_head == PTR_W'(i)))
        w_nent[i] = '0;
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i]  <= '0;
        r_id[i]   <= '0;
        r_data[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i]  <= w_nent[i];
        r_id[i]   <= w_nid[i];
        r_data[i] <= w_ndata[i];
      end
      if (w_alloc)
        r_tail <= r_tail + PTR_W'(1);
      if (w_pop)
        r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
    end
  end

`ifdef RVFPM_RESQ_FFLAGS_EN
  assign result_fflags = result_valid ? r_ff[r_head] : '0;
  assign fflags_acc    = r_acc;

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_ff[i] <= '0;
      r_acc <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        r_ff[i] <= w_nff[i];
      r_acc <= (fflags_clr ? 5'd0 : r_acc) |
               ((result_valid && result_ready) ? r_ff[r_head] : 5'd0);
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/rvfpm_result_queue.md
Name: rvfpm_result_queue

Overview:
- Parametrised, synthesizable in-order result/commit tracking queue for the rvfpm coprocessor, sitting between the execution channels and the CORE-V-XIF result interface.
- Allocates one entry per accepted issue and captures results from NUM_CH execution channels by instruction id.
- Matches commit/kill by id and retires committed results to the core in issue order with valid/ready back-pressure.
- Replaces single-result polling with DEPTH outstanding instructions and multiple producers.

Parameters:
DEPTH, 4, number of outstanding instructions (power of 2, ≥2)
NUM_CH, 2, number of execution writeback channels
X_ID_WIDTH, 4, XIF instruction id width
DATA_WIDTH, 32, result data width (FLEN)

Ports:
ck  in  1  clock
rst  in  1  asynchronous active-low reset
alloc_valid  in  1  accepted issue to track
alloc_ready  out  1  space available (count < DEPTH)
alloc_id  in  X_ID_WIDTH  issue id
alloc_rd  in  5  destination register
alloc_wb  in  1  instruction writes back a result
ch_valid  in  NUM_CH  per-channel result valid
ch_id  in  NUM_CH*X_ID_WIDTH  per-channel id
ch_data  in  NUM_CH*DATA_WIDTH  per-channel data
commit_valid  in  1  XIF commit strobe
commit_id  in  X_ID_WIDTH  committed id
commit_kill  in  1  kill instead of commit
result_valid  out  1  XIF result valid
result_ready  in  1  core accepts result
result_id  out  X_ID_WIDTH  result id
result_rd  out  5  result rd
result_data  out  DATA_WIDTH  result data
result_we  out  1  register write enable (always 1 when valid)
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst low, async): all entries FREE; head = tail = count = 0; result_valid = 0; result_id, result_rd and result_data = 0; alloc_ready = 1.
- Entry fields: state, id, rd, wb, done, committed, killed, data.
- Entry states: FREE -> PEND on alloc. PEND -> RETIRE when done & committed. PEND or RETIRE -> DROP on kill. RETIRE or DROP -> FREE when popped.
- Alloc: when alloc_valid & alloc_ready, write entry[tail] and advance tail.
  - Tail wraps modulo DEPTH.
  - alloc_ready depends only on registered count; no same-cycle alloc-on-pop when full.
- Channel writeback: each ch_valid sets done and data in the PEND entry whose id matches.
  - A write with no matching entry, or to a DROP entry, is discarded.
  - Two channels hitting the same id in one cycle: the lowest channel index wins.
- Commit: commit_valid sets committed, or killed if commit_kill, on the matching entry.
  - Commit for an id being allocated in the same cycle applies to the new entry. The core may commit before accept.
  - Commit to an unknown id is ignored.
- Entries with wb = 0 never wait for ch_valid; done is set at alloc.
- Head output is combinational from registered head state.
  - result_valid = head RETIRE & wb.
  - Latency: result_valid rises 1 cycle after the later of the channel write and the commit.
- Pop conditions:
  - result_valid & result_ready.
  - Head in DROP, or RETIRE with wb = 0: popped silently, one per cycle, no result_valid.
- Stall: while result_valid & !result_ready, result_id, result_rd, result_data and result_we hold stable.
- Simultaneous alloc and pop: count unchanged; head and tail both advance.
- Full: alloc_ready = 0 until a pop registers.
- Empty: result_valid = 0.
- Reset mid-operation discards all entries immediately; no result is emitted.

Optional Feature:
RVFPM_RESQ_FFLAGS_EN
- Defined:
  - Adds input ch_fflags (NUM_CH*5) stored per entry.
  - Adds output result_fflags (5), valid with result_valid.
  - Adds output fflags_acc (5): sticky OR of fflags of popped results, cleared by reset or by input fflags_clr (1 cycle).
- Undefined: these ports and storage are absent; behaviour is otherwise identical.

Decomposition:
- Package pa_rvfpm gets:
  - resq_state_e (FREE/PEND/RETIRE/DROP);
  - resq_entry_t struct;
  - localparam RESQ_PTR_W = $clog2(DEPTH).
- One natural sub-module, rvfpm_resq_id_match: combinational id-to-one-hot entry lookup, instantiated for the commit port and each channel.

Test Plan:
- Alloc id 1 (rd 3), ch0 writes id 1 data 0x3F800000, commit id 1 -> next cycle result_valid = 1, id 1, rd 3, data 0x3F800000; pops on result_ready.
- Alloc ids 2, 3; ch1 finishes id 3 first; commit both -> result id 2 emitted before id 3 (in order); id 3 held until id 2 pops.
- Alloc id 4, commit_kill id 4, then ch0 writes id 4 -> no result_valid; count returns to 0 in 1 cycle.
- Fill DEPTH=4 entries -> alloc_ready = 0; hold result_ready = 0 for 5 cycles -> outputs stable; one pop -> alloc_ready = 1 next cycle.
- commit_valid for id 5 in the same cycle as alloc id 5, then ch0 writes -> result emitted (commit not lost).
- Assert rst low with 3 entries pending -> result_valid = 0 and count = 0 immediately; late ch writes are ignored after reset.
